// File: rtl/zdos_trap.sv
// DOS paging trap decoder: turns fclk-synchronous Z80 bus activity into
// single-fclk DOS enter/leave strobes and VG93 / system port access strobes.
module zdos_trap #(
    parameter logic [7:0] TRAP_PAGE = 8'h3D,
    parameter int         FILT      = 2
) (
    input  logic        fclk,
    input  logic        rst_n,
    input  logic        zpos,
    input  logic [15:0] za,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        dos,
    input  logic        rom48,
    input  logic        trap_en,
    output logic        dos_turn_on,
    output logic        dos_turn_off,
    output logic        vg_rdwr_fclk,
    output logic [1:0]  vg_a,
    output logic        vg_wr,
    output logic        sys_rdwr_fclk
);

    typedef enum logic {
        IDLE,
        FETCH_DONE
    } m1_state_t;

    typedef enum logic {
        IO_IDLE,
        IO_HOLD
    } io_state_t;

    localparam logic [1:0] FILT_LAST = 2'(FILT - 1);

    m1_state_t  m1_state;
    io_state_t  io_state;
    logic [1:0] io_cnt;
    logic [7:0] io_port;

    logic m1_fetch;
    logic m1_intack;
    logic trap_hit;
    logic leave_hit;
    logic port_vg;
    logic port_sys;
    logic io_cond;
    logic same_port;

    always_comb begin
        m1_fetch  = zpos & ~m1_n & ~mreq_n;
        m1_intack = zpos & ~m1_n & ~iorq_n;
        trap_hit  = trap_en & rom48 & ~dos & (za[15:8] == TRAP_PAGE);
        leave_hit = dos & (za[15:14] != 2'b00);
    end

    always_comb begin
        port_vg   = (za[7:0] == 8'h1F) | (za[7:0] == 8'h3F) |
                    (za[7:0] == 8'h5F) | (za[7:0] == 8'h7F);
        port_sys  = (za[7:0] == 8'hFF);
        io_cond   = ~iorq_n & m1_n & (~rd_n | ~wr_n) & dos &
                    (port_vg | port_sys);
        same_port = (io_cnt == 2'd0) | (za[7:0] == io_port);
    end

    // One decision per M1 cycle; FETCH_DONE absorbs the remaining zpos edges.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            m1_state     <= IDLE;
            dos_turn_on  <= 1'b0;
            dos_turn_off <= 1'b0;
        end else begin
            dos_turn_on  <= 1'b0;
            dos_turn_off <= 1'b0;
            unique case (m1_state)
                IDLE: begin
                    if (m1_fetch) begin
                        m1_state     <= FETCH_DONE;
                        dos_turn_on  <= trap_hit;
                        dos_turn_off <= leave_hit;
                    end else if (m1_intack) begin
                        m1_state <= FETCH_DONE;
                    end
                end
                FETCH_DONE: begin
                    if (m1_n) begin
                        m1_state <= IDLE;
                    end
                end
                default: m1_state <= IDLE;
            endcase
        end
    end

    // Port access must be stable for FILT fclk cycles before it is accepted.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            io_state      <= IO_IDLE;
            io_cnt        <= 2'd0;
            io_port       <= 8'h00;
            vg_rdwr_fclk  <= 1'b0;
            sys_rdwr_fclk <= 1'b0;
            vg_a          <= 2'b00;
            vg_wr         <= 1'b0;
        end else begin
            vg_rdwr_fclk  <= 1'b0;
            sys_rdwr_fclk <= 1'b0;
            unique case (io_state)
                IO_IDLE: begin
                    if (io_cond && same_port) begin
                        if (io_cnt == FILT_LAST) begin
                            io_state      <= IO_HOLD;
                            io_cnt        <= 2'd0;
                            vg_rdwr_fclk  <= port_vg;
                            sys_rdwr_fclk <= port_sys;
                            vg_a          <= za[6:5];
                            vg_wr         <= ~wr_n;
                        end else begin
                            io_cnt  <= io_cnt + 2'd1;
                            io_port <= za[7:0];
                        end
                    end else begin
                        io_cnt <= 2'd0;
                    end
                end
                IO_HOLD: begin
                    if (iorq_n) begin
                        io_state <= IO_IDLE;
                    end
                end
                default: io_state <= IO_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zdos_trap.sv
// Bench for zdos_trap: directed scenarios plus randomized bus transactions
// checked against a per-transaction model of the trap rules.
module tb_zdos_trap;

    localparam logic [7:0] TRAP_PAGE = 8'h3D;
    localparam int         FILT      = 2;

    logic        fclk;
    logic        rst_n;
    logic        zpos;
    logic [15:0] za;
    logic        m1_n;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        dos;
    logic        rom48;
    logic        trap_en;
    logic        dos_turn_on;
    logic        dos_turn_off;
    logic        vg_rdwr_fclk;
    logic [1:0]  vg_a;
    logic        vg_wr;
    logic        sys_rdwr_fclk;

    int checks;
    int errors;

    int n_on;
    int n_off;
    int n_vg;
    int n_sys;
    int n_both;
    logic [1:0] got_a;
    logic       got_wr;
    logic       first_on;
    logic       first_off;

    zdos_trap #(
        .TRAP_PAGE(TRAP_PAGE),
        .FILT(FILT)
    ) dut (
        .fclk(fclk),
        .rst_n(rst_n),
        .zpos(zpos),
        .za(za),
        .m1_n(m1_n),
        .mreq_n(mreq_n),
        .iorq_n(iorq_n),
        .rd_n(rd_n),
        .wr_n(wr_n),
        .dos(dos),
        .rom48(rom48),
        .trap_en(trap_en),
        .dos_turn_on(dos_turn_on),
        .dos_turn_off(dos_turn_off),
        .vg_rdwr_fclk(vg_rdwr_fclk),
        .vg_a(vg_a),
        .vg_wr(vg_wr),
        .sys_rdwr_fclk(sys_rdwr_fclk)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    task automatic clr();
        n_on = 0;
        n_off = 0;
        n_vg = 0;
        n_sys = 0;
        n_both = 0;
        got_a = 2'b00;
        got_wr = 1'b0;
    endtask

    task automatic tick();
        @(posedge fclk);
        #1;
        if (dos_turn_on) n_on++;
        if (dos_turn_off) n_off++;
        if (dos_turn_on && dos_turn_off) n_both++;
        if (sys_rdwr_fclk) n_sys++;
        if (vg_rdwr_fclk) begin
            n_vg++;
            got_a = vg_a;
            got_wr = vg_wr;
        end
    endtask

    task automatic bus_idle();
        zpos = 1'b0;
        m1_n = 1'b1;
        mreq_n = 1'b1;
        iorq_n = 1'b1;
        rd_n = 1'b1;
        wr_n = 1'b1;
    endtask

    task automatic m1_cycle(input logic [15:0] a, input int nz,
                            input logic ack);
        clr();
        za = a;
        m1_n = 1'b0;
        if (ack) iorq_n = 1'b0;
        else begin
            mreq_n = 1'b0;
            rd_n = 1'b0;
        end
        for (int i = 0; i < nz; i++) begin
            zpos = 1'b1;
            tick();
            if (i == 0) begin
                first_on = dos_turn_on;
                first_off = dos_turn_off;
            end
            zpos = 1'b0;
            tick();
        end
        bus_idle();
        tick();
        tick();
    endtask

    task automatic io_cycle(input logic [15:0] a, input logic wr,
                            input int w);
        clr();
        za = a;
        m1_n = 1'b1;
        iorq_n = 1'b0;
        if (wr) wr_n = 1'b0;
        else rd_n = 1'b0;
        repeat (w) tick();
        bus_idle();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dos = 1'b0;
        rom48 = 1'b0;
        trap_en = 1'b0;
        za = 16'h0000;
        bus_idle();
        clr();
        tick();
        tick();
        checks++;
        if ({dos_turn_on, dos_turn_off, vg_rdwr_fclk, sys_rdwr_fclk,
             vg_wr, vg_a} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b%b%b%b%b%b want 000000",
                     dos_turn_on, dos_turn_off, vg_rdwr_fclk,
                     sys_rdwr_fclk, vg_wr, vg_a);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_turn_on();
        dos = 1'b0;
        rom48 = 1'b1;
        trap_en = 1'b1;
        m1_cycle(16'h3D2F, 1, 1'b0);
        checks++;
        if (first_on !== 1'b1 || n_on != 1 || n_off != 0) begin
            errors++;
            $display("FAIL turn_on first=%b on=%0d off=%0d want 1 1 0",
                     first_on, n_on, n_off);
        end
        rom48 = 1'b0;
        m1_cycle(16'h3D2F, 1, 1'b0);
        checks++;
        if (n_on != 0) begin
            errors++;
            $display("FAIL turn_on_no_rom48 on=%0d want 0", n_on);
        end
    endtask

    task automatic test_turn_off();
        dos = 1'b1;
        rom48 = 1'b1;
        trap_en = 1'b1;
        m1_cycle(16'h8000, 1, 1'b0);
        checks++;
        if (first_off !== 1'b1 || n_off != 1 || n_on != 0) begin
            errors++;
            $display("FAIL turn_off first=%b off=%0d on=%0d want 1 1 0",
                     first_off, n_off, n_on);
        end
        m1_cycle(16'h3D00, 1, 1'b0);
        checks++;
        if (n_on != 0 || n_off != 0) begin
            errors++;
            $display("FAIL dos_in_trap_page on=%0d off=%0d want 0 0",
                     n_on, n_off);
        end
    endtask

    task automatic test_long_m1();
        dos = 1'b0;
        rom48 = 1'b1;
        trap_en = 1'b1;
        m1_cycle(16'h3D13, 6, 1'b0);
        checks++;
        if (n_on != 1) begin
            errors++;
            $display("FAIL long_m1 on=%0d want 1", n_on);
        end
        trap_en = 1'b0;
        m1_cycle(16'h3D13, 6, 1'b0);
        checks++;
        if (n_on != 0) begin
            errors++;
            $display("FAIL trap_disabled on=%0d want 0", n_on);
        end
    endtask

    task automatic test_io();
        dos = 1'b1;
        io_cycle(16'hA57F, 1'b1, 4);
        checks++;
        if (n_vg != 1 || n_sys != 0 || got_a !== 2'b11 || got_wr !== 1'b1)
        begin
            errors++;
            $display("FAIL out_7f vg=%0d sys=%0d a=%b wr=%b want 1 0 11 1",
                     n_vg, n_sys, got_a, got_wr);
        end
        io_cycle(16'h12FF, 1'b0, 4);
        checks++;
        if (n_sys != 1 || n_vg != 0) begin
            errors++;
            $display("FAIL in_ff sys=%0d vg=%0d want 1 0", n_sys, n_vg);
        end
        io_cycle(16'h003F, 1'b0, FILT);
        checks++;
        if (n_vg != 1 || got_a !== 2'b01 || got_wr !== 1'b0) begin
            errors++;
            $display("FAIL in_3f_min vg=%0d a=%b wr=%b want 1 01 0",
                     n_vg, got_a, got_wr);
        end
    endtask

    task automatic test_no_io();
        dos = 1'b1;
        io_cycle(16'h001F, 1'b0, 1);
        checks++;
        if (n_vg != 0 || n_sys != 0) begin
            errors++;
            $display("FAIL glitch_1f vg=%0d sys=%0d want 0 0", n_vg, n_sys);
        end
        m1_cycle(16'h00FF, 3, 1'b1);
        checks++;
        if (n_vg + n_sys + n_on + n_off != 0) begin
            errors++;
            $display("FAIL int_ack pulses=%0d want 0",
                     n_vg + n_sys + n_on + n_off);
        end
        dos = 1'b0;
        io_cycle(16'h003F, 1'b1, 4);
        checks++;
        if (n_vg != 0) begin
            errors++;
            $display("FAIL no_dos_3f vg=%0d want 0", n_vg);
        end
        dos = 1'b1;
        clr();
        za = 16'h005F;
        iorq_n = 1'b0;
        rd_n = 1'b0;
        tick();
        dos = 1'b0;
        repeat (3) tick();
        bus_idle();
        tick();
        tick();
        checks++;
        if (n_vg != 0) begin
            errors++;
            $display("FAIL dos_fall vg=%0d want 0", n_vg);
        end
    endtask

    task automatic test_reset_mid();
        dos = 1'b0;
        rom48 = 1'b1;
        trap_en = 1'b1;
        clr();
        za = 16'h3D2F;
        m1_n = 1'b0;
        mreq_n = 1'b0;
        rd_n = 1'b0;
        zpos = 1'b1;
        tick();
        zpos = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (n_on != 1 || dos_turn_on !== 1'b0) begin
            errors++;
            $display("FAIL reset_fetch on_seen=%0d on_now=%b want 1 0",
                     n_on, dos_turn_on);
        end
        tick();
        rst_n = 1'b1;
        clr();
        zpos = 1'b1;
        tick();
        zpos = 1'b0;
        checks++;
        if (dos_turn_on !== 1'b1) begin
            errors++;
            $display("FAIL m1_after_reset on=%b want 1", dos_turn_on);
        end
        bus_idle();
        tick();
        tick();
        dos = 1'b1;
        clr();
        za = 16'h007F;
        iorq_n = 1'b0;
        wr_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (n_vg != 1 || vg_a !== 2'b00 || vg_wr !== 1'b0 ||
            vg_rdwr_fclk !== 1'b0) begin
            errors++;
            $display("FAIL reset_io_hold vg_seen=%0d a=%b wr=%b want 1 00 0",
                     n_vg, vg_a, vg_wr);
        end
        bus_idle();
        tick();
        rst_n = 1'b1;
        tick();
        m1_cycle(16'hC000, 1, 1'b0);
        checks++;
        if (n_off != 1 || n_on != 0) begin
            errors++;
            $display("FAIL fetch_after_reset off=%0d on=%0d want 1 0",
                     n_off, n_on);
        end
    endtask

    task automatic test_random();
        logic [7:0] ports[8];
        logic [15:0] a;
        logic exp_on;
        logic exp_off;
        logic exp_pulse;
        logic valid;
        logic wr;
        int kind;
        int w;
        ports = '{8'h1F, 8'h3F, 8'h5F, 8'h7F, 8'hFF, 8'h1E, 8'hFE, 8'h9F};
        for (int t = 0; t < 150; t++) begin
            dos = 1'($urandom);
            rom48 = 1'($urandom);
            trap_en = 1'($urandom);
            kind = $urandom_range(0, 2);
            a = 16'($urandom);
            if (kind == 0) begin
                if ($urandom_range(0, 2) == 0) a[15:8] = TRAP_PAGE;
                m1_cycle(a, $urandom_range(1, 4), 1'b0);
                exp_on = trap_en && rom48 && !dos && a[15:8] == TRAP_PAGE;
                exp_off = dos && a[15:14] != 2'b00;
                checks++;
                if (n_on != int'(exp_on) || n_off != int'(exp_off) ||
                    first_on !== exp_on || first_off !== exp_off ||
                    n_both != 0 || n_vg + n_sys != 0) begin
                    errors++;
                    $display("FAIL rnd_m1 a=%h on=%0d off=%0d want %0d %0d",
                             a, n_on, n_off, exp_on, exp_off);
                end
            end else if (kind == 1) begin
                m1_cycle(a, $urandom_range(1, 3), 1'b1);
                checks++;
                if (n_on + n_off + n_vg + n_sys != 0) begin
                    errors++;
                    $display("FAIL rnd_intack a=%h pulses=%0d want 0",
                             a, n_on + n_off + n_vg + n_sys);
                end
            end else begin
                a[7:0] = ports[$urandom_range(0, 7)];
                wr = 1'($urandom);
                w = $urandom_range(1, 5);
                io_cycle(a, wr, w);
                valid = a[7:0] inside {8'h1F, 8'h3F, 8'h5F, 8'h7F, 8'hFF};
                exp_pulse = dos && valid && w >= FILT;
                checks++;
                if (n_vg != int'(exp_pulse && a[7:0] != 8'hFF) ||
                    n_sys != int'(exp_pulse && a[7:0] == 8'hFF)) begin
                    errors++;
                    $display("FAIL rnd_io a=%h w=%0d dos=%b vg=%0d sys=%0d",
                             a, w, dos, n_vg, n_sys);
                end
                if (exp_pulse && a[7:0] != 8'hFF) begin
                    checks++;
                    if (got_a !== a[6:5] || got_wr !== wr) begin
                        errors++;
                        $display("FAIL rnd_vg_latch a=%b wr=%b want %b %b",
                                 got_a, got_wr, a[6:5], wr);
                    end
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        first_on = 1'b0;
        first_off = 1'b0;
        test_reset();
        test_turn_on();
        test_turn_off();
        test_long_m1();
        test_io();
        test_no_io();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
